acc_core_mc: RTL and testbench
==============================

Name: acc_core_mc

Overview:
- Parametrised multi-cycle accumulator core; next generation of the fixed 2-bit-cycle load/store/incr sequencer.
- Fetches one-word instructions from a shared memory port and decodes opcode plus operand address.
- Executes load/store/add/read-modify-write increment/jump/branch/halt over a req/ack memory handshake that tolerates wait states.
- Sits between the memory arbiter and debug/IO logic; acc and pc are exported for observation.

Parameters:
- DATA_W, 16, data/instruction word width; must be > OP_W.
- ADDR_W, 15, memory address width.
- OP_W, 4, opcode field width, instruction bits [OP_W-1:0].
- RESET_PC, 'h2400, PC value after reset and after RST opcode.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1=write, 0=read; valid while mem_req
- mem_addr  out  ADDR_W  request address; stable while mem_req && !mem_ack
- mem_wdata  out  DATA_W  write data; stable while mem_req && mem_we
- mem_rdata  in  DATA_W  read data; sampled on the cycle mem_ack=1
- mem_ack  in  1  completes the current request; ignored when mem_req=0
- acc  out  DATA_W  accumulator
- pc  out  ADDR_W  program counter
- halted  out  1  core is in HALTED state
- instr_done  out  1  one-cycle pulse per retired instruction
- illegal  out  1  one-cycle pulse on decode of an undefined opcode

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, acc=0, ir=0, tmp=0. mem_req=0, mem_we=0, instr_done=0, illegal=0, halted=0. mem_addr/mem_wdata are don't-care while mem_req=0.
- Instruction word: op=ir[OP_W-1:0]. ea = ir[DATA_W-1:OP_W], zero-extended or truncated to ADDR_W.
- Opcodes: 0 NOP, 1 LOAD, 2 STORE, 3 INCR, 4 ADD, 5 JMP, 6 JZ, 7 HALT, 8 RST. All other values are illegal and execute as NOP with illegal pulsed.
- mem_req/mem_we/mem_addr/mem_wdata are decoded from registered state only; there is no combinational path from mem_ack to any output.
- IDLE: leaves reset; -> FETCH on the next clock.
- FETCH: req=1, we=0, addr=pc.
  - On ack: ir<=rdata, pc<=pc+1 (wraps modulo 2^ADDR_W), -> DECODE.
- DECODE: 1 cycle, req=0.
  - NOP/illegal -> FETCH.
  - LOAD/ADD/INCR -> MEM_RD.
  - STORE -> MEM_WR.
  - JMP: pc<=ea -> FETCH.
  - JZ: if acc==0 then pc<=ea; -> FETCH.
  - HALT -> HALTED.
  - RST: pc<=RESET_PC, acc unchanged -> FETCH.
- MEM_RD: req=1, we=0, addr=ea. On ack:
  - LOAD: acc<=rdata -> FETCH.
  - ADD: acc<=acc+rdata modulo 2^DATA_W, carry discarded -> FETCH.
  - INCR: tmp<=rdata+1 modulo 2^DATA_W -> MEM_WR.
- MEM_WR: req=1, we=1, addr=ea, wdata=acc (STORE) or tmp (INCR). On ack -> FETCH. acc is unchanged by INCR.
- HALTED: req=0, halted=1; the core stays here until rst_n is asserted.
- Request rule: mem_req stays high with constant we/addr/wdata until the cycle mem_ack=1. The cycle after ack, the core either drops req or issues the next request.
- Zero-wait memory (ack in the first req cycle) gives these minimum latencies, fetch to instr_done:
  - NOP/JMP/JZ/RST/HALT: 2 cycles.
  - LOAD/ADD/STORE: 3 cycles.
  - INCR: 4 cycles.
  - Each wait cycle adds one.
- instr_done: registered; high for exactly one cycle, in the cycle after the instruction's final transition (into FETCH or HALTED).
- illegal: registered; high for one cycle, in the cycle after DECODE of an undefined opcode; coincides with that instruction's instr_done.
- Reset mid-transaction: the request is abandoned immediately and the core restarts from IDLE. No partial register update occurs for an unacked access.

Test Plan:
- Reset release, zero-wait memory with mem[0x2400]=0x0051 (LOAD ea=5) and mem[5]=0x1234 -> first req addr=0x2400, we=0; then req addr=0x005, we=0; acc=0x1234 and pc=0x2401 at instr_done, which occurs 3 cycles after the first fetch ack cycle.
- INCR ea=6 with mem[6]=0xFFFF and a 2-cycle wait on each access -> read of 0x006 then write of 0x006 with wdata=0x0000; acc unchanged; addr/we/wdata stable throughout both wait periods.
- Program STORE(acc=0x00AA) to 0x10; ADD mem[0x10] -> write 0x00AA to 0x010; then acc=0x0154.
- JZ with acc=0, ea=0x123 -> next fetch addr=0x0123; repeat with acc=1 -> next fetch addr=pc+1.
- pc=0x7FFF fetching NOP -> pc wraps to 0x0000; opcode 0xF -> illegal and instr_done pulse together, state continues to FETCH; HALT -> halted=1, mem_req=0 for 20 cycles.
- rst_n=0 asserted while MEM_WR is awaiting ack -> mem_req drops asynchronously, target memory is not written; after release, fetch restarts at 0x2400 with acc=0.

Source files
------------

// File: rtl/acc_core_mc.sv
// Multi-cycle accumulator core: fetch, decode and execute over a req/ack memory port.
// Latency: 2 (control), 3 (LOAD/ADD/STORE), 4 (INCR) cycles from fetch ack to instr_done, +1 per wait cycle.
// Backpressure: each request is held with stable address/data until mem_ack; no output depends on mem_ack.
module acc_core_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int OP_W = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'('h2400)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              instr_done,
    output logic              illegal
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WR,
        S_HALTED
    } state_t;

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
    localparam logic [OP_W-1:0] OP_INCR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JMP   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JZ    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_RST   = OP_W'(8);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   tmp_q, tmp_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    logic [OP_W-1:0]     op;
    logic [ADDR_W-1:0]   ea;

    assign op = ir_q[OP_W-1:0];
    // Operand field is zero-extended or truncated to the address width.
    assign ea = ADDR_W'(ir_q[DATA_W-1:OP_W]);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        acc_d     = acc_q;
        ir_d      = ir_q;
        tmp_d     = tmp_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_FETCH;
                done_d  = 1'b1;
                case (op)
                    OP_NOP: ;
                    OP_LOAD, OP_ADD, OP_INCR: begin
                        state_d = S_MEM_RD;
                        done_d  = 1'b0;
                    end
                    OP_STORE: begin
                        state_d = S_MEM_WR;
                        done_d  = 1'b0;
                    end
                    OP_JMP: pc_d = ea;
                    OP_JZ: begin
                        if (acc_q == '0) pc_d = ea;
                    end
                    OP_HALT: state_d = S_HALTED;
                    OP_RST: pc_d = RESET_PC;
                    default: illegal_d = 1'b1;
                endcase
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    state_d = S_FETCH;
                    done_d  = 1'b1;
                    if (op == OP_LOAD) begin
                        acc_d = mem_rdata;
                    end else if (op == OP_ADD) begin
                        acc_d = acc_q + mem_rdata;
                    end else begin
                        // INCR: keep the incremented value for the write-back phase.
                        tmp_d   = mem_rdata + DATA_W'(1);
                        state_d = S_MEM_WR;
                        done_d  = 1'b0;
                    end
                end
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    state_d = S_FETCH;
                    done_d  = 1'b1;
                end
            end
            S_HALTED: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            acc_q     <= '0;
            ir_q      <= '0;
            tmp_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            acc_q     <= acc_d;
            ir_q      <= ir_d;
            tmp_q     <= tmp_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_req    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign mem_we     = (state_q == S_MEM_WR);
    assign mem_addr   = (state_q == S_FETCH) ? pc_q : ea;
    assign mem_wdata  = (op == OP_STORE) ? acc_q : tmp_q;
    assign acc        = acc_q;
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALTED);
    assign instr_done = done_q;
    assign illegal    = illegal_q;
endmodule

// File: tb/tb_acc_core_mc.sv
// Bench for acc_core_mc: memory responder with wait states plus an instruction-level reference model.
module tb_acc_core_mc;
    localparam int DW = 16;
    localparam int AW = 15;
    localparam logic [AW-1:0] RPC = 15'h2400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr, pc;
    logic [DW-1:0] mem_wdata, mem_rdata, acc;
    logic          halted, instr_done, illegal;

    logic          w_req, w_we, w_ack, w_halted, w_done, w_illegal;
    logic [AW-1:0] w_addr, w_pc;
    logic [DW-1:0] w_wdata, w_rdata, w_acc;

    acc_core_mc #(.DATA_W(16), .ADDR_W(15), .OP_W(4), .RESET_PC(15'h2400)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .acc(acc), .pc(pc),
        .halted(halted), .instr_done(instr_done), .illegal(illegal));

    // Second core starting at the top of the address space to observe pc wrap.
    acc_core_mc #(.DATA_W(16), .ADDR_W(15), .OP_W(4), .RESET_PC(15'h7FFF)) u_wrap (
        .clk(clk), .rst_n(rst_n), .mem_req(w_req), .mem_we(w_we), .mem_addr(w_addr),
        .mem_wdata(w_wdata), .mem_rdata(w_rdata), .mem_ack(w_ack), .acc(w_acc), .pc(w_pc),
        .halted(w_halted), .instr_done(w_done), .illegal(w_illegal));
    assign w_ack   = w_req;
    assign w_rdata = (w_addr == 15'h7FFF) ? 16'h0000 : 16'h0007;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wait_mode = 0;
    int done_cnt = 0;

    logic [DW-1:0] mem  [0:32767];
    logic [DW-1:0] mmem [0:32767];

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        int            waits;
        int            ack_cyc;
    } acc_t;
    acc_t q[$];
    acc_t a_hist[$];
    logic [DW-1:0] h_acc[$];
    logic [AW-1:0] h_pc[$];
    int            h_lat[$];
    logic          h_ill[$];

    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    logic          m_halt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick_wait(input logic we);
        case (wait_mode)
            0: return 0;
            1: return 2;
            2: return int'($urandom_range(0, 3));
            default: return we ? 1000 : 0;
        endcase
    endfunction

    // Memory responder: ack/rdata driven mid-cycle, writes committed on the acked edge.
    bit            busy = 0;
    int            wleft = 0;
    int            r_waits = 0;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wd;
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ack = 1'b0;
            busy = 0;
        end else begin
            if (!busy) begin
                busy = 1;
                r_addr = mem_addr;
                r_we = mem_we;
                r_wd = mem_wdata;
                r_waits = 0;
                wleft = pick_wait(mem_we);
            end else begin
                chk("req_stable_addr", 32'(mem_addr), 32'(r_addr));
                chk("req_stable_we", 32'(mem_we), 32'(r_we));
                if (r_we) chk("req_stable_wdata", 32'(mem_wdata), 32'(r_wd));
            end
            if (wleft == 0) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ack = 1'b0;
                wleft--;
                r_waits++;
            end
        end
    end

    always @(posedge clk) begin
        acc_t e;
        if (rst_n && mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            e.addr = mem_addr;
            e.we = mem_we;
            e.wdata = mem_wdata;
            e.waits = r_waits;
            e.ack_cyc = cyc;
            q.push_back(e);
            a_hist.push_back(e);
            busy = 0;
        end
        cyc = cyc + 1;
    end

    // Instruction-level reference: one architectural step per retired instruction.
    task automatic model_step();
        acc_t f, a, b;
        logic [DW-1:0] ir, v;
        logic [3:0] op;
        logic [AW-1:0] ea;
        int need, lat;
        logic ill;
        ill = 1'b0;
        ir = mmem[m_pc];
        op = ir[3:0];
        ea = {3'b000, ir[15:4]};
        need = (op == 4'd1 || op == 4'd2 || op == 4'd4) ? 2 : (op == 4'd3) ? 3 : 1;
        chk("access_count", 32'(q.size()), 32'(need));
        if (q.size() != need) begin
            q.delete();
            return;
        end
        f = q.pop_front();
        chk("fetch_addr", 32'(f.addr), 32'(m_pc));
        chk("fetch_we", 32'(f.we), 0);
        m_pc = m_pc + 15'd1;
        lat = 2;
        case (op)
            4'd1, 4'd4: begin
                a = q.pop_front();
                chk("rd_addr", 32'(a.addr), 32'(ea));
                chk("rd_we", 32'(a.we), 0);
                m_acc = (op == 4'd1) ? mmem[ea] : m_acc + mmem[ea];
                lat = 3 + a.waits;
            end
            4'd2: begin
                a = q.pop_front();
                chk("st_addr", 32'(a.addr), 32'(ea));
                chk("st_we", 32'(a.we), 1);
                chk("st_wdata", 32'(a.wdata), 32'(m_acc));
                mmem[ea] = m_acc;
                lat = 3 + a.waits;
            end
            4'd3: begin
                a = q.pop_front();
                b = q.pop_front();
                v = mmem[ea] + 16'd1;
                chk("incr_rd_addr", 32'(a.addr), 32'(ea));
                chk("incr_rd_we", 32'(a.we), 0);
                chk("incr_wr_addr", 32'(b.addr), 32'(ea));
                chk("incr_wr_we", 32'(b.we), 1);
                chk("incr_wr_wdata", 32'(b.wdata), 32'(v));
                mmem[ea] = v;
                lat = 4 + a.waits + b.waits;
            end
            4'd5: m_pc = ea;
            4'd6: if (m_acc == 16'd0) m_pc = ea;
            4'd7: m_halt = 1'b1;
            4'd8: m_pc = RPC;
            4'd0: ;
            default: ill = 1'b1;
        endcase
        chk("acc", 32'(acc), 32'(m_acc));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("illegal", 32'(illegal), 32'(ill));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("latency", 32'(cyc - f.ack_cyc), 32'(lat));
        h_acc.push_back(acc);
        h_pc.push_back(pc);
        h_lat.push_back(cyc - f.ack_cyc);
        h_ill.push_back(illegal);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (illegal) chk("illegal_with_done", 32'(instr_done), 1);
            if (instr_done) begin
                model_step();
                done_cnt++;
            end
        end
    end

    task automatic put(input logic [AW-1:0] addr, input logic [DW-1:0] w);
        mem[addr] = w;
        mmem[addr] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) begin
            mem[i] = '0;
            mmem[i] = '0;
        end
    endtask

    task automatic model_reset();
        m_pc = RPC;
        m_acc = '0;
        m_halt = 1'b0;
        q.delete();
        a_hist.delete();
        h_acc.delete();
        h_pc.delete();
        h_lat.delete();
        h_ill.delete();
        done_cnt = 0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, input string nm);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({nm, "_halted"}, 32'(halted), 1);
        chk({nm, "_no_extra_access"}, 32'(q.size()), 0);
    endtask

    task automatic wait_req(input int budget, input string nm);
        int n = 0;
        while (!mem_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_req_seen"}, 32'(mem_req), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [11:0] ea12;
        int n;
        model_reset();
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_instr_done", 32'(instr_done), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_pc", 32'(pc), 32'h2400);

        // LOAD ea=5, zero-wait memory
        put(15'h2400, 16'h0051); put(15'h2401, 16'h0007); put(15'h0005, 16'h1234);
        wait_mode = 0;
        #2 rst_n = 1'b1;
        wait_req(10, "t1");
        chk("t1_first_addr", 32'(mem_addr), 32'h2400);
        chk("t1_first_we", 32'(mem_we), 0);
        run_until_halt(100, "t1");
        chk("t1_rd_addr", 32'(a_hist[1].addr), 32'h0005);
        chk("t1_acc", 32'(h_acc[0]), 32'h1234);
        chk("t1_pc", 32'(h_pc[0]), 32'h2401);
        chk("t1_lat", 32'(h_lat[0]), 3);

        // INCR ea=6 with two wait cycles per access
        clear_mem();
        put(15'h2400, 16'h0071); put(15'h2401, 16'h0063); put(15'h2402, 16'h0007);
        put(15'h0007, 16'h5A5A); put(15'h0006, 16'hFFFF);
        wait_mode = 1;
        reset_dut();
        run_until_halt(200, "t2");
        chk("t2_rd_addr", 32'(a_hist[3].addr), 32'h0006);
        chk("t2_wr_we", 32'(a_hist[4].we), 1);
        chk("t2_wr_wdata", 32'(a_hist[4].wdata), 32'h0000);
        chk("t2_mem6", 32'(mem[6]), 32'h0000);
        chk("t2_acc", 32'(h_acc[1]), 32'h5A5A);
        chk("t2_lat", 32'(h_lat[1]), 8);

        // STORE then ADD of the same location, random waits
        clear_mem();
        put(15'h2400, 16'h0081); put(15'h2401, 16'h0102); put(15'h2402, 16'h0104);
        put(15'h2403, 16'h0007); put(15'h0008, 16'h00AA);
        wait_mode = 2;
        reset_dut();
        run_until_halt(200, "t3");
        chk("t3_mem10", 32'(mem[16]), 32'h00AA);
        chk("t3_acc", 32'(h_acc[2]), 32'h0154);

        // JZ taken with acc=0, not taken with acc=1
        clear_mem();
        put(15'h2400, 16'h1236); put(15'h0123, 16'h0091); put(15'h0124, 16'h2006);
        put(15'h0125, 16'h0007); put(15'h0009, 16'h0001);
        wait_mode = 0;
        reset_dut();
        run_until_halt(200, "t4");
        chk("t4_jz_taken_fetch", 32'(a_hist[1].addr), 32'h0123);
        chk("t4_jz_taken_pc", 32'(h_pc[0]), 32'h0123);
        chk("t4_jz_not_taken_fetch", 32'(a_hist[4].addr), 32'h0125);
        chk("t4_final_pc", 32'(pc), 32'h0126);

        // Illegal opcode, HALT hold, and pc wrap on the second core
        clear_mem();
        put(15'h2400, 16'h000F); put(15'h2401, 16'h0007);
        reset_dut();
        n = 0;
        while (!w_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_done_seen", 32'(w_done), 1);
        chk("wrap_pc", 32'(w_pc), 32'h0000);
        chk("wrap_next_fetch", 32'(w_addr), 32'h0000);
        run_until_halt(100, "t5");
        chk("t5_illegal", 32'(h_ill[0]), 1);
        chk("t5_pc_after_illegal", 32'(h_pc[0]), 32'h2401);
        chk("wrap_halted", 32'(w_halted), 1);
        chk("wrap_final_pc", 32'(w_pc), 32'h0001);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_hold_halted", 32'(halted), 1);
            chk("t5_hold_req", 32'(mem_req), 0);
            chk("t5_hold_done", 32'(instr_done), 0);
        end

        // Reset while a STORE awaits ack
        clear_mem();
        put(15'h2400, 16'h0051); put(15'h2401, 16'h0102); put(15'h2402, 16'h0007);
        put(15'h0005, 16'h0077); put(15'h0010, 16'hBEEF);
        wait_mode = 3;
        reset_dut();
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_write_pending", 32'(mem_req && mem_we), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t6_req_async_drop", 32'(mem_req), 0);
        repeat (2) @(negedge clk);
        chk("t6_mem_untouched", 32'(mem[16]), 32'hBEEF);
        wait_mode = 0;
        model_reset();
        #2 rst_n = 1'b1;
        wait_req(10, "t6");
        chk("t6_restart_addr", 32'(mem_addr), 32'h2400);
        chk("t6_restart_we", 32'(mem_we), 0);
        chk("t6_restart_acc", 32'(acc), 0);
        run_until_halt(100, "t6");
        chk("t6_mem_final", 32'(mem[16]), 32'h0077);

        // Random programs at 0x800 with random wait states
        for (int r = 0; r < 4; r++) begin
            clear_mem();
            put(15'h2400, 16'h8005);
            for (int i = 0; i < 128; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd7 && $urandom_range(0, 3) != 0) op = 4'd0;
                if (op == 4'd5 || op == 4'd6) ea12 = 12'(32'h800 + $urandom_range(0, 127));
                else ea12 = 12'($urandom_range(0, 63));
                put(15'h0800 + 15'(i), {ea12, op});
            end
            for (int i = 0; i < 64; i++) put(15'(i), 16'($urandom));
            wait_mode = 2;
            reset_dut();
            n = 0;
            while (!halted && done_cnt < 200 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            if (halted) chk("rand_no_extra_access", 32'(q.size()), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
